// File: rtl/stdp_weight_reg.sv
// Per-synapse weight register with saturating STDP inc/dec updates gated by a timed
// learning window, plus boundary flags and a per-window saturation-attempt counter.
//
// state | meaning
// IDLE  | window closed; inc/dec ignored, only load_en can change the weight
// LEARN | window open; win_cnt counts cycles, inc/dec update the weight
module stdp_weight_reg #(
  parameter int WBITS   = 3,
  parameter int WMAX    = 7,
  parameter int WINIT   = 0,
  parameter int WIN_LEN = 16,
  parameter int SATBITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               learn_start,
  input  logic               learn_stop,
  input  logic               inc,
  input  logic               dec,
  input  logic               load_en,
  input  logic [WBITS-1:0]   load_val,
  output logic [WBITS-1:0]   weight,
  output logic               at_min,
  output logic               at_max,
  output logic               learning,
  output logic               updated,
  output logic               conflict,
  output logic               learn_done,
  output logic [SATBITS-1:0] sat_count
);

  localparam int CW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [WBITS-1:0]   W_MAX    = WBITS'(WMAX);
  localparam logic [WBITS-1:0]   W_INIT   = WBITS'(WINIT);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIN_LEN - 1);
  localparam logic [SATBITS-1:0] SAT_TOP  = {SATBITS{1'b1}};

  typedef enum logic {IDLE, LEARN} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      win_cnt, win_cnt_nxt;
  logic [WBITS-1:0]   weight_nxt;
  logic [SATBITS-1:0] sat_nxt;
  logic               done_nxt, upd_nxt, conf_nxt, sat_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      win_cnt    <= '0;
      weight     <= W_INIT;
      sat_count  <= '0;
      updated    <= 1'b0;
      conflict   <= 1'b0;
      learn_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      win_cnt    <= win_cnt_nxt;
      weight     <= weight_nxt;
      sat_count  <= sat_nxt;
      updated    <= upd_nxt;
      conflict   <= conf_nxt;
      learn_done <= done_nxt;
    end
  end

  // Window control: a start inside LEARN restarts the window and outranks stop.
  always_comb begin
    state_nxt   = state;
    win_cnt_nxt = '0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (learn_start) state_nxt = LEARN;
      end
      LEARN: begin
        if (learn_start) begin
          state_nxt = LEARN;
        end else if (learn_stop || (win_cnt == CNT_LAST)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          win_cnt_nxt = win_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Weight update: load overrides inc/dec; updates only happen while LEARN.
  always_comb begin
    weight_nxt = weight;
    upd_nxt    = 1'b0;
    conf_nxt   = 1'b0;
    sat_evt    = 1'b0;
    if (load_en) begin
      weight_nxt = (load_val > W_MAX) ? W_MAX : load_val;
    end else if (state == LEARN) begin
      if (inc && dec) begin
        conf_nxt = 1'b1;
      end else if (inc) begin
        if (weight >= W_MAX) sat_evt = 1'b1;
        else begin
          weight_nxt = weight + WBITS'(1);
          upd_nxt    = 1'b1;
        end
      end else if (dec) begin
        if (weight == '0) sat_evt = 1'b1;
        else begin
          weight_nxt = weight - WBITS'(1);
          upd_nxt    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sat_nxt = sat_count;
    if (learn_start) sat_nxt = '0;
    else if (sat_evt && (sat_count != SAT_TOP)) sat_nxt = sat_count + SATBITS'(1);
  end

  assign at_min   = (weight == '0);
  assign at_max   = (weight == W_MAX);
  assign learning = (state == LEARN);

endmodule
